// File: rtl/wb_matrix_regs.sv
`default_nettype none
// ============================================================================
// Module   : wb_matrix_regs
// Purpose  : Wishbone B4 pipelined row registers for an LED matrix, with commit
//            FSM; WB_MATRIX_REGS_SHADOW_EN adds a tear-free display buffer.
// Revision : 1.0 - initial release
// ============================================================================
module wb_matrix_regs #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int REG_COUNT     = 8,
    parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic [WB_DATA_WIDTH-1:0] o_wb_rdata,
    input  logic [WB_ADDR_WIDTH-1:0] i_scan_row,
    output logic [WB_DATA_WIDTH-1:0] o_scan_data,
    input  logic                     i_frame_start,
    output logic [REG_COUNT-1:0]     o_dirty,
    output logic [7:0]               o_commit_count
);

    localparam logic [31:0] c_reg_count = REG_COUNT;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_commit;

    logic [WB_DATA_WIDTH-1:0] r_back [REG_COUNT];
    logic [WB_DATA_WIDTH-1:0] r_rdata;
    logic [WB_DATA_WIDTH-1:0] r_scan_data;
    logic [WB_DATA_WIDTH-1:0] w_scan_row_data;
    logic [REG_COUNT-1:0]     r_dirty;
    logic [7:0]               r_commit_count;
    logic                     r_ack_pending;
    logic                     w_beat;
    logic                     w_wr_beat;
    logic                     w_rd_beat;
    logic                     w_addr_ok;
    logic                     w_scan_ok;

    // ---------------- commit state machine ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_frame_start && r_dirty[REG_COUNT-1]) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_wb_stall = w_commit;

    // ---------------- bus side ----------------
    assign w_beat    = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign w_wr_beat = w_beat && i_wb_we;
    assign w_rd_beat = w_beat && !i_wb_we;
    assign w_addr_ok = 32'(i_wb_addr) < c_reg_count;
    assign w_scan_ok = 32'(i_scan_row) < c_reg_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                r_back[r] <= '0;
            end
        end else if (w_wr_beat && w_addr_ok) begin
            for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                if (i_wb_sel[b]) begin
                    r_back[i_wb_addr][b*8 +: 8] <= i_wb_wdata[b*8 +: 8];
                end
            end
        end
    end

    // The ack is gated by the live cyc so an abandoned cycle sees no response,
    // while the write itself has already landed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_pending <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_ack_pending <= w_beat;
            r_rdata       <= (w_rd_beat && w_addr_ok) ? r_back[i_wb_addr] : '0;
        end
    end

    assign o_wb_ack   = r_ack_pending && i_wb_cyc;
    assign o_wb_rdata = o_wb_ack ? r_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dirty        <= '0;
            r_commit_count <= 8'd0;
        end else if (w_commit) begin
            r_dirty        <= '0;
            r_commit_count <= r_commit_count + 8'd1;
        end else if (w_wr_beat && w_addr_ok) begin
            r_dirty[i_wb_addr] <= 1'b1;
        end
    end

    assign o_dirty        = r_dirty;
    assign o_commit_count = r_commit_count;

    // ---------------- scan side ----------------
`ifdef WB_MATRIX_REGS_SHADOW_EN
    logic [WB_DATA_WIDTH-1:0] r_disp [REG_COUNT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                r_disp[r] <= '0;
            end
        end else if (w_commit) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                r_disp[r] <= r_back[r];
            end
        end
    end

    assign w_scan_row_data = w_scan_ok ? r_disp[i_scan_row] : '0;
`else
    assign w_scan_row_data = w_scan_ok ? r_back[i_scan_row] : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_data <= '0;
        end else begin
            r_scan_data <= w_scan_row_data;
        end
    end

    assign o_scan_data = r_scan_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_matrix_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_matrix_regs
// Purpose  : Directed self-checking bench for wb_matrix_regs (either build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_matrix_regs;

    logic        clk;
    logic        reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [2:0]  i_wb_addr;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_wdata;
    logic        o_wb_ack, o_wb_stall;
    logic [31:0] o_wb_rdata;
    logic [2:0]  i_scan_row;
    logic [31:0] o_scan_data;
    logic        i_frame_start;
    logic [7:0]  o_dirty;
    logic [7:0]  o_commit_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_matrix_regs dut (
        .clk            (clk),
        .reset          (reset),
        .i_wb_cyc       (i_wb_cyc),
        .i_wb_stb       (i_wb_stb),
        .i_wb_we        (i_wb_we),
        .i_wb_addr      (i_wb_addr),
        .i_wb_sel       (i_wb_sel),
        .i_wb_wdata     (i_wb_wdata),
        .o_wb_ack       (o_wb_ack),
        .o_wb_stall     (o_wb_stall),
        .o_wb_rdata     (o_wb_rdata),
        .i_scan_row     (i_scan_row),
        .o_scan_data    (o_scan_data),
        .i_frame_start  (i_frame_start),
        .o_dirty        (o_dirty),
        .o_commit_count (o_commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we,
                         input logic [2:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
        i_wb_cyc   = cyc;
        i_wb_stb   = stb;
        i_wb_we    = we;
        i_wb_addr  = addr;
        i_wb_wdata = data;
        i_wb_sel   = sel;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        n_checks += 6;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", o_wb_ack); end
        if (o_wb_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", o_wb_rdata); end
        if (o_wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", o_wb_stall); end
        if (o_scan_data !== 32'h0) begin n_fail++; $display("FAIL reset_scan got %h want 0", o_scan_data); end
        if (o_dirty !== 8'h00) begin n_fail++; $display("FAIL reset_dirty got %h want 00", o_dirty); end
        if (o_commit_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_commit_count); end
        reset = 1'b0;
    endtask

    task automatic test_burst();
        logic [7:0] exp_dirty;
        drive(1, 1, 1, 3'd0, 32'h00666600, 4'hF);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 7) drive(1, 1, 1, 3'(i + 1), 32'h00666600 + 32'(i + 1), 4'hF);
            else       drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
            #1;
            exp_dirty = 8'((1 << (i + 1)) - 1);
            n_checks += 2;
            if (o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL burst_ack beat %0d got %b want 1", i, o_wb_ack); end
            if (o_dirty !== exp_dirty) begin n_fail++; $display("FAIL burst_dirty beat %0d got %h want %h", i, o_dirty, exp_dirty); end
        end
        step();
        #1;
        n_checks += 2;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL burst_ack_end got %b want 0", o_wb_ack); end
        if (o_dirty !== 8'hFF) begin n_fail++; $display("FAIL burst_dirty_end got %h want ff", o_dirty); end
    endtask

    task automatic test_byte_lanes();
        drive(1, 1, 1, 3'd2, 32'hAABBCCDD, 4'hF);
        step();
        drive(1, 1, 1, 3'd2, 32'h11223344, 4'b0101);
        step();
        drive(1, 1, 0, 3'd2, 32'h0, 4'h0);
        step();
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks += 2;
        if (o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL lanes_ack got %b want 1", o_wb_ack); end
        if (o_wb_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL lanes_rdata got %h want aa22cc44", o_wb_rdata); end
        step();
        #1;
        n_checks += 2;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL lanes_ack_idle got %b want 0", o_wb_ack); end
        if (o_wb_rdata !== 32'h0) begin n_fail++; $display("FAIL lanes_rdata_idle got %h want 0", o_wb_rdata); end
    endtask

    task automatic test_commit();
        logic [31:0] exp_pre;
`ifdef WB_MATRIX_REGS_SHADOW_EN
        exp_pre = 32'h00000000;
`else
        exp_pre = 32'h00666600;
`endif
        i_scan_row = 3'd0;
        step();
        #1;
        n_checks++;
        if (o_scan_data !== exp_pre) begin n_fail++; $display("FAIL commit_scan_pre got %h want %h", o_scan_data, exp_pre); end
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        #1;
        n_checks += 2;
        if (o_wb_stall !== 1'b1) begin n_fail++; $display("FAIL commit_stall got %b want 1", o_wb_stall); end
        if (o_commit_count !== 8'd0) begin n_fail++; $display("FAIL commit_count_during got %0d want 0", o_commit_count); end
        step();
        #1;
        n_checks += 3;
        if (o_wb_stall !== 1'b0) begin n_fail++; $display("FAIL commit_stall_after got %b want 0", o_wb_stall); end
        if (o_commit_count !== 8'd1) begin n_fail++; $display("FAIL commit_count got %0d want 1", o_commit_count); end
        if (o_dirty !== 8'h00) begin n_fail++; $display("FAIL commit_dirty got %h want 00", o_dirty); end
        step();
        #1;
        n_checks++;
        if (o_scan_data !== 32'h00666600) begin n_fail++; $display("FAIL commit_scan_post got %h want 00666600", o_scan_data); end
    endtask

    task automatic test_scan_latency();
        logic [31:0] exp_late;
`ifdef WB_MATRIX_REGS_SHADOW_EN
        exp_late = 32'h00666603;
`else
        exp_late = 32'h60000006;
`endif
        i_scan_row = 3'd3;
        drive(1, 1, 1, 3'd3, 32'h60000006, 4'hF);
        step();
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (o_scan_data !== 32'h00666603) begin n_fail++; $display("FAIL scan_one_cycle got %h want 00666603", o_scan_data); end
        step();
        #1;
        n_checks++;
        if (o_scan_data !== exp_late) begin n_fail++; $display("FAIL scan_two_cycles got %h want %h", o_scan_data, exp_late); end
    endtask

    task automatic test_ignore_and_abandon();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        #1;
        n_checks += 2;
        if (o_wb_stall !== 1'b0) begin n_fail++; $display("FAIL ignore_stall got %b want 0", o_wb_stall); end
        if (o_commit_count !== 8'd1) begin n_fail++; $display("FAIL ignore_count got %0d want 1", o_commit_count); end
        drive(1, 1, 1, 3'd5, 32'hDEADBEEF, 4'hF);
        step();
        drive(0, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL abandon_ack got %b want 0", o_wb_ack); end
        drive(1, 1, 0, 3'd5, 32'h0, 4'h0);
        step();
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks += 3;
        if (o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL abandon_read_ack got %b want 1", o_wb_ack); end
        if (o_wb_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abandon_read_data got %h want deadbeef", o_wb_rdata); end
        if (o_dirty !== 8'h28) begin n_fail++; $display("FAIL abandon_dirty got %h want 28", o_dirty); end
    endtask

    task automatic test_commit_overlap();
        drive(1, 1, 1, 3'd7, 32'h11111111, 4'hF);
        step();
        drive(1, 1, 1, 3'd6, 32'h66666666, 4'hF);
        i_frame_start = 1'b1;
        step();
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        i_frame_start = 1'b0;
        #1;
        n_checks += 2;
        if (o_wb_stall !== 1'b1) begin n_fail++; $display("FAIL overlap_stall got %b want 1", o_wb_stall); end
        if (o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL overlap_ack got %b want 1", o_wb_ack); end
        step();
        #1;
        n_checks += 3;
        if (o_dirty !== 8'h00) begin n_fail++; $display("FAIL overlap_dirty got %h want 00", o_dirty); end
        if (o_commit_count !== 8'd2) begin n_fail++; $display("FAIL overlap_count got %0d want 2", o_commit_count); end
        if (o_wb_stall !== 1'b0) begin n_fail++; $display("FAIL overlap_stall_after got %b want 0", o_wb_stall); end
        i_scan_row = 3'd6;
        drive(1, 1, 0, 3'd6, 32'h0, 4'h0);
        step();
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks += 2;
        if (o_wb_rdata !== 32'h66666666) begin n_fail++; $display("FAIL overlap_rdata got %h want 66666666", o_wb_rdata); end
        if (o_scan_data !== 32'h66666666) begin n_fail++; $display("FAIL overlap_scan got %h want 66666666", o_scan_data); end
    endtask

    task automatic test_reset_mid_burst();
        drive(1, 1, 1, 3'd0, 32'hAAAAAAAA, 4'hF);
        step();
        drive(1, 1, 1, 3'd1, 32'hBBBBBBBB, 4'hF);
        step();
        drive(1, 1, 1, 3'd2, 32'hCCCCCCCC, 4'hF);
        step();
        drive(1, 1, 1, 3'd3, 32'hDDDDDDDD, 4'hF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks += 4;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack got %b want 0", o_wb_ack); end
        if (o_dirty !== 8'h00) begin n_fail++; $display("FAIL midrst_dirty got %h want 00", o_dirty); end
        if (o_commit_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", o_commit_count); end
        if (o_wb_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %b want 0", o_wb_stall); end
        i_scan_row = 3'd0;
        drive(1, 1, 0, 3'd0, 32'h0, 4'h0);
        step();
        drive(1, 0, 0, 3'd0, 32'h0, 4'h0);
        #1;
        n_checks += 3;
        if (o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL midrst_read_ack got %b want 1", o_wb_ack); end
        if (o_wb_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_read_data got %h want 0", o_wb_rdata); end
        if (o_scan_data !== 32'h0) begin n_fail++; $display("FAIL midrst_scan got %h want 0", o_scan_data); end
    endtask

    initial begin
        reset         = 1'b1;
        i_frame_start = 1'b0;
        i_scan_row    = 3'd0;
        drive(0, 0, 0, 3'd0, 32'h0, 4'h0);
        test_reset();
        test_burst();
        test_byte_lanes();
        test_commit();
        test_scan_latency();
        test_ignore_and_abandon();
        test_commit_overlap();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
